// File: rtl/input_controller_if.sv
// Purpose: button/tick inputs and direction/step/status outputs of the input controller.
// Latency: carries no logic; every output signal is driven from a register in the controller.
// Backpressure: none; the buttons are levels, and Overflow reports a push lost to a full queue.
interface input_controller_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             UpPressed;
    logic             DownPressed;
    logic             LeftPressed;
    logic             RightPressed;
    logic             CenterPressed;
    logic             Tick;
    logic [1:0]       Dir;
    logic             Step;
    logic             Paused;
    logic [CNT_W-1:0] QueueCount;
    logic             Overflow;

    // Button and tick source side (the debouncers and the game timer).
    modport master (
        output UpPressed, DownPressed, LeftPressed, RightPressed, CenterPressed, Tick,
        input  Dir, Step, Paused, QueueCount, Overflow
    );

    // Controller side.
    modport slave (
        input  UpPressed, DownPressed, LeftPressed, RightPressed, CenterPressed, Tick,
        output Dir, Step, Paused, QueueCount, Overflow
    );
endinterface

// File: rtl/input_controller.sv
// Purpose: turns debounced button edges into filtered direction requests, queues them, and commits one per tick.
// Latency: a press is queued on its sampling edge; a tick shows Step and the new Dir one cycle later.
// Backpressure: none upstream; when the queue is full and nothing pops, the request is dropped and Overflow pulses.
module input_controller #(
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic               Clock,
    input  logic               Reset,
    input_controller_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    // Directions: UP=0, DOWN=1, LEFT=2, RIGHT=3. The opposite of a
    // direction is therefore the same code with bit 0 flipped.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    logic [4:0]       levelNow;
    logic [4:0]       prevLevel;
    logic [4:0]       buttonEvent;
    logic [1:0]       dirReg;
    logic             stepReg;
    logic             pausedReg;
    logic             overflowReg;
    logic [CNT_W-1:0] countReg;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [1:0]       queueMem [DEPTH];

    logic             hasDirEvent;
    logic [1:0]       reqDir;
    logic [1:0]       refDir;
    logic             reqValid;
    logic             doPop;
    logic             doPush;
    logic             dropReq;
    logic             tickActive;

    // Bit order: {Center, Right, Left, Down, Up}.
    assign levelNow    = {bus.CenterPressed, bus.RightPressed, bus.LeftPressed,
                          bus.DownPressed, bus.UpPressed};
    assign buttonEvent = levelNow & ~prevLevel;

    // Pick the winning direction event (Up > Down > Left > Right) and filter it
    // against the newest queued direction, or the committed one if the queue is empty.
    always_comb begin
        hasDirEvent = 1'b1;
        reqDir      = DIR_UP;
        if (buttonEvent[0])      reqDir = DIR_UP;
        else if (buttonEvent[1]) reqDir = DIR_DOWN;
        else if (buttonEvent[2]) reqDir = DIR_LEFT;
        else if (buttonEvent[3]) reqDir = DIR_RIGHT;
        else                     hasDirEvent = 1'b0;

        refDir     = (countReg != '0) ? queueMem[wrPtr - PTR_ONE] : dirReg;
        reqValid   = hasDirEvent && !pausedReg &&
                     (reqDir != refDir) && (reqDir != (refDir ^ 2'b01));
        tickActive = bus.Tick && !pausedReg;
        doPop      = tickActive && (countReg != '0);
        doPush     = reqValid && ((countReg != FULL_COUNT) || doPop);
        dropReq    = reqValid && (countReg == FULL_COUNT) && !doPop;
    end

    // Control state: edge history, pause toggle, committed direction, pulses and queue pointers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            prevLevel   <= '1;
            dirReg      <= INIT_DIR;
            stepReg     <= 1'b0;
            pausedReg   <= 1'b0;
            overflowReg <= 1'b0;
            countReg    <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
        end else begin
            prevLevel   <= levelNow;
            stepReg     <= tickActive;
            overflowReg <= dropReq;
            if (buttonEvent[4]) pausedReg <= ~pausedReg;
            if (doPop) begin
                dirReg <= queueMem[rdPtr];
                rdPtr  <= rdPtr + PTR_ONE;
            end
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            countReg <= countReg + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // Queue storage; the contents need no reset because the count gates every read.
    always_ff @(posedge Clock) begin
        if (!Reset && doPush) queueMem[wrPtr] <= reqDir;
    end

    assign bus.Dir        = dirReg;
    assign bus.Step       = stepReg;
    assign bus.Paused     = pausedReg;
    assign bus.QueueCount = countReg;
    assign bus.Overflow   = overflowReg;
endmodule

// File: tb/tb_input_controller.sv
// Purpose: directed check of the input controller: filtering, queue order, overflow, pause and reset.
// Latency: inputs change 1 ns after a rising edge; outputs are checked 1 ns after the edge that registers them.
// Backpressure: not applicable; the stimulus is a fixed linear sequence.
module tb_input_controller;
    logic Clock = 1'b0;
    logic Reset;
    int   testsRun  = 0;
    int   failCount = 0;

    always #5 Clock = ~Clock;

    input_controller_if #(.DEPTH(4)) ctrlIf ();

    input_controller #(.DEPTH(4), .INIT_DIR(2'd3)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (ctrlIf.slave)
    );

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // 0=Up 1=Down 2=Left 3=Right 4=Center
    task automatic setButton(input int which, input logic value);
        case (which)
            0: ctrlIf.UpPressed     = value;
            1: ctrlIf.DownPressed   = value;
            2: ctrlIf.LeftPressed   = value;
            3: ctrlIf.RightPressed  = value;
            default: ctrlIf.CenterPressed = value;
        endcase
    endtask

    task automatic press(input int which);
        setButton(which, 1'b1);
        cyc();
        setButton(which, 1'b0);
        cyc();
    endtask

    // One tick; checks the committed direction and the Step pulse.
    task automatic tickCheck(input string tag, input logic [1:0] expDir, input logic expStep);
        ctrlIf.Tick = 1'b1;
        cyc();
        ctrlIf.Tick = 1'b0;
        check({tag, "_step"}, ctrlIf.Step, expStep);
        check({tag, "_dir"}, ctrlIf.Dir, expDir);
        cyc();
        check({tag, "_step_off"}, ctrlIf.Step, 1'b0);
    endtask

    initial begin
        Reset = 1'b1;
        ctrlIf.UpPressed = 0; ctrlIf.DownPressed = 0; ctrlIf.LeftPressed = 0;
        ctrlIf.RightPressed = 0; ctrlIf.CenterPressed = 0; ctrlIf.Tick = 0;
        cyc(); cyc();
        Reset = 1'b0;
        cyc();

        // Reset state and a tick on an empty queue.
        check("rst_dir", ctrlIf.Dir, 3);
        check("rst_count", ctrlIf.QueueCount, 0);
        check("rst_paused", ctrlIf.Paused, 0);
        check("rst_step", ctrlIf.Step, 0);
        check("rst_ovf", ctrlIf.Overflow, 0);
        tickCheck("empty_tick", 2'd3, 1'b1);
        check("empty_tick_count", ctrlIf.QueueCount, 0);

        // Reversal and duplicate filtering against Dir=RIGHT.
        press(2);
        check("filt_left", ctrlIf.QueueCount, 0);
        press(3);
        check("filt_right", ctrlIf.QueueCount, 0);
        press(0);
        check("filt_up", ctrlIf.QueueCount, 1);
        tickCheck("filt_tick", 2'd0, 1'b1);
        check("filt_tick_count", ctrlIf.QueueCount, 0);

        // Back to RIGHT, then queue order and overflow.
        press(3);
        tickCheck("to_right", 2'd3, 1'b1);
        press(0); press(2); press(1);
        check("q3_count", ctrlIf.QueueCount, 3);
        press(3);
        check("q4_count", ctrlIf.QueueCount, 4);
        check("q4_ovf", ctrlIf.Overflow, 0);
        ctrlIf.UpPressed = 1'b1;
        cyc();
        ctrlIf.UpPressed = 1'b0;
        check("ovf_pulse", ctrlIf.Overflow, 1);
        check("ovf_count", ctrlIf.QueueCount, 4);
        cyc();
        check("ovf_clear", ctrlIf.Overflow, 0);
        tickCheck("pop1", 2'd0, 1'b1);
        tickCheck("pop2", 2'd2, 1'b1);
        tickCheck("pop3", 2'd1, 1'b1);
        tickCheck("pop4", 2'd3, 1'b1);
        check("pop_count", ctrlIf.QueueCount, 0);

        // Pause discards presses and ticks.
        ctrlIf.CenterPressed = 1'b1;
        cyc();
        ctrlIf.CenterPressed = 1'b0;
        check("pause_on", ctrlIf.Paused, 1);
        cyc();
        press(0);
        check("pause_count", ctrlIf.QueueCount, 0);
        for (int i = 0; i < 3; i++) tickCheck("pause_tick", 2'd3, 1'b0);
        press(4);
        check("pause_off", ctrlIf.Paused, 0);

        // Full queue with tail UP, then push and pop in the same cycle.
        press(0);
        tickCheck("to_up", 2'd0, 1'b1);
        press(2); press(0); press(3); press(0);
        check("full_count", ctrlIf.QueueCount, 4);
        ctrlIf.LeftPressed = 1'b1;
        ctrlIf.Tick = 1'b1;
        cyc();
        ctrlIf.LeftPressed = 1'b0;
        ctrlIf.Tick = 1'b0;
        check("pp_dir", ctrlIf.Dir, 2);
        check("pp_count", ctrlIf.QueueCount, 4);
        check("pp_ovf", ctrlIf.Overflow, 0);
        check("pp_step", ctrlIf.Step, 1);
        cyc();
        check("pp_ovf_after", ctrlIf.Overflow, 0);
        tickCheck("pp_pop1", 2'd0, 1'b1);
        tickCheck("pp_pop2", 2'd3, 1'b1);
        tickCheck("pp_pop3", 2'd0, 1'b1);
        tickCheck("pp_pop4", 2'd2, 1'b1);

        // Reset mid-queue and mid-pause, with Up held through the release.
        press(1); press(3);
        check("pre_rst_count", ctrlIf.QueueCount, 2);
        press(4);
        check("pre_rst_paused", ctrlIf.Paused, 1);
        Reset = 1'b1;
        ctrlIf.UpPressed = 1'b1;
        cyc();
        Reset = 1'b0;
        check("mid_rst_count", ctrlIf.QueueCount, 0);
        check("mid_rst_dir", ctrlIf.Dir, 3);
        check("mid_rst_paused", ctrlIf.Paused, 0);
        cyc(); cyc();
        check("held_up_count", ctrlIf.QueueCount, 0);
        ctrlIf.UpPressed = 1'b0;
        cyc();

        // Queue two entries, then Reset alongside a Tick.
        press(0); press(2);
        check("q2_count", ctrlIf.QueueCount, 2);
        Reset = 1'b1;
        ctrlIf.Tick = 1'b1;
        cyc();
        Reset = 1'b0;
        ctrlIf.Tick = 1'b0;
        check("rst_tick_count", ctrlIf.QueueCount, 0);
        check("rst_tick_dir", ctrlIf.Dir, 3);
        check("rst_tick_step", ctrlIf.Step, 0);
        cyc();
        check("rst_tick_step2", ctrlIf.Step, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule

// File: doc/input_controller.md
# input_controller

Direction-request front end for the snake game. It takes the debounced button levels and turns their rising edges into filtered direction requests, held in a small FIFO. On each game tick it commits exactly one queued direction. It also owns the pause state. It sits between the per-button Debouncer instances and the snake movement logic, which consumes `Dir` and `Step` instead of raw buttons.

## Interface
Parameters:
- DEPTH, 4, direction FIFO capacity; power of two, at least 2.
- INIT_DIR, 2'd3 (`DIR_RIGHT`), direction after reset.

Ports:
- Clock  in  1  debouncer-domain clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high.
- UpPressed  in  1  debounced level.
- DownPressed  in  1  debounced level.
- LeftPressed  in  1  debounced level.
- RightPressed  in  1  debounced level.
- CenterPressed  in  1  debounced level; pause toggle.
- Tick  in  1  one-cycle game-step request, synchronous to Clock.
- Dir  out  2  committed direction. Encoding: UP=0, DOWN=1, LEFT=2, RIGHT=3.
- Step  out  1  one-cycle pulse; the mover advances the snake one cell using Dir.
- Paused  out  1  pause state.
- QueueCount  out  clog2(DEPTH+1)  current FIFO occupancy.
- Overflow  out  1  one-cycle pulse when an otherwise valid request is dropped because the FIFO is full.

## Operation
- **Edge detect:** previous-level registers for all five buttons. An event is `level & ~prev`. Previous-level registers reset to 1, so a button held through reset produces no event.
- **Priority:** when several direction events occur in one cycle, the order is Up > Down > Left > Right. Only the winner is considered; the rest are discarded.
- **Reference direction:** the last enqueued entry (FIFO tail) if the FIFO is non-empty; otherwise Dir.
- **Filter:** reject the request if it equals the reference (duplicate) or is its opposite (UP/DOWN, LEFT/RIGHT reversal). A rejected request has no effect and does not pulse Overflow.
- **Pause:** while Paused=1, every direction event is discarded. A Center event toggles Paused.
- **Push:** a request that passes the filter is written to the FIFO tail.
  - If count==DEPTH and no pop occurs this cycle, the request is dropped and Overflow pulses.
- **Tick with Paused=0:**
  - Step is asserted for exactly one cycle.
  - If the FIFO is non-empty, the head is popped into Dir on the same edge.
  - If the FIFO is empty, Dir holds.
- **Tick with Paused=1:** no Step, no pop.
- **Simultaneous events:** all decisions in a cycle use pre-edge state.
  - Center plus Tick: Tick is judged against the old Paused value.
  - Center plus direction event: the direction event is judged against the old Paused value.
  - Push plus pop: both happen and count is unchanged. The filter uses the pre-pop reference. A push at count==DEPTH alongside a pop is accepted with no Overflow.
  - Push plus Tick with an empty FIFO: nothing is popped, the push is filtered against the current Dir, and count becomes 1.
- **FIFO storage:** circular buffer with clog2(DEPTH)-bit read and write pointers that wrap modulo DEPTH. Count is held separately, with range 0..DEPTH.
- **Reset values:**
  - FIFO emptied: pointers=0, QueueCount=0.
  - Dir=INIT_DIR, Paused=0, Step=0, Overflow=0, previous levels=all 1.
  - Reset has priority over every event in the same cycle, including mid-queue or mid-pause.

## Timing
- All outputs are registered.
- A button sampled high at edge k, with its previous level 0, is enqueued at edge k. QueueCount reflects the push from cycle k+1.
- Tick sampled high at edge t: Step=1 and the new Dir are visible during cycle t+1. Step=0 from t+2 unless Tick repeats.
- Back-to-back Ticks on consecutive cycles each pop one entry and each produce one Step.
- A Center event at edge k makes Paused change visibly at cycle k+1.
- Overflow is high for the single cycle after the dropped push.
- No combinational path from any input to any output.

## Test plan
- **Reset, then Tick:** assert Reset, release, then pulse Tick once -> Dir=3, QueueCount=0, Paused=0; Step high for exactly one cycle, Dir stays 3.
- **Reversal and duplicate filtering:** with Dir=RIGHT, press Left then Right then Up, then pulse Tick -> QueueCount=1 after the Up press; after Tick, Dir=0 (UP) and QueueCount=0.
- **Queue ordering and overflow:** with DEPTH=4 and Dir=RIGHT, press Up, Left, Down, Right, Up (no Ticks) -> QueueCount=4 after the fourth press; the fifth press pulses Overflow once. Four Ticks then yield Dir 0, 2, 1, 3 in that order.
- **Pause:** Center edge gives Paused=1. While paused, Up press plus three Ticks -> no Step, QueueCount=0, Dir unchanged. A second Center edge gives Paused=0.
- **Same-cycle push/pop at full:** FIFO full (tail=UP), then Left press and Tick in the same cycle -> head popped to Dir, LEFT enqueued, QueueCount stays 4, Overflow=0.
- **Held button and reset mid-queue:** hold Up through reset release -> no enqueue. Queue 2 entries, assert Reset one cycle -> QueueCount=0, Dir=3, Step=0.
